// File: rtl/divisor_norm_reg_pkg.sv
// Shared divider definitions: state encoding and default datapath width.
package divisor_norm_reg_pkg;

   localparam int unsigned DIV_WIDTH = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_NORM = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // 2'd3 is unused; the FSM decodes it as IDLE
   typedef enum logic [1:0] {
      S_IDLE    = ST_IDLE,
      S_NORM    = ST_NORM,
      S_DONE    = ST_DONE,
      S_ILLEGAL = 2'd3
   } norm_state_e;

endpackage

// File: rtl/divisor_norm_reg.sv
// Divisor register: keeps the raw divisor, left-normalises a working copy one
// bit per cycle while counting shifts, and flags a zero divisor.
module divisor_norm_reg
   import divisor_norm_reg_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] raw_out,
   output logic [WIDTH-1:0] norm_out,
   output logic [SHW-1:0]   shift_cnt,
   output logic             busy,
   output logic             ready,
   output logic             div_zero
);

   norm_state_e      state, state_d;
   logic [WIDTH-1:0] raw_d;
   logic [WIDTH-1:0] norm_d;
   logic [SHW-1:0]   cnt_d;
   logic             zero_d;

   // State and datapath registers; busy/ready track the state being entered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         raw_out   <= '0;
         norm_out  <= '0;
         shift_cnt <= '0;
         div_zero  <= 1'b0;
         busy      <= 1'b0;
         ready     <= 1'b0;
      end else begin
         state     <= state_d;
         raw_out   <= raw_d;
         norm_out  <= norm_d;
         shift_cnt <= cnt_d;
         div_zero  <= zero_d;
         busy      <= (state_d == S_NORM);
         ready     <= (state_d == S_DONE);
      end
   end

   // Next state and datapath: clear beats load beats normal progress
   always_comb begin
      state_d = state;
      raw_d   = raw_out;
      norm_d  = norm_out;
      cnt_d   = shift_cnt;
      zero_d  = div_zero;
      if (clear) begin
         state_d = S_IDLE;
         raw_d   = '0;
         norm_d  = '0;
         cnt_d   = '0;
         zero_d  = 1'b0;
      end else if (load) begin
         raw_d   = din;
         norm_d  = din;
         cnt_d   = '0;
         zero_d  = (din == '0);
         // zero never enters NORM, which keeps the shift loop bounded
         state_d = ((din == '0) || din[WIDTH-1]) ? S_DONE : S_NORM;
      end else begin
         case (state)
            S_IDLE: state_d = S_IDLE;
            S_NORM: begin
               norm_d = {norm_out[WIDTH-2:0], 1'b0};
               cnt_d  = shift_cnt + SHW'(1);
               if (norm_out[WIDTH-2]) state_d = S_DONE;
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divisor_norm_reg.sv
// Bench for divisor_norm_reg: 8- and 16-bit instances share stimulus and are
// checked every cycle against a leading-zero based model, plus directed checks.
module tb_divisor_norm_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic        clear;
   logic [15:0] din;
   logic [7:0]  din8;

   logic [7:0]  raw8, norm8;
   logic [2:0]  cnt8;
   logic        busy8, ready8, dz8;
   logic [15:0] raw16, norm16;
   logic [3:0]  cnt16;
   logic        busy16, ready16, dz16;

   int vectors = 0;
   int errors  = 0;

   // model: per instance, whether a load is live, what was loaded, and edges since the load
   logic        m_act [2];
   logic [15:0] m_raw [2];
   int          m_lz  [2];
   int          m_t   [2];

   assign din8 = din[7:0];

   always #5 clk = ~clk;

   divisor_norm_reg #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .load(load), .clear(clear), .din(din8),
      .raw_out(raw8), .norm_out(norm8), .shift_cnt(cnt8),
      .busy(busy8), .ready(ready8), .div_zero(dz8)
   );

   divisor_norm_reg #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .load(load), .clear(clear), .din(din),
      .raw_out(raw16), .norm_out(norm16), .shift_cnt(cnt16),
      .busy(busy16), .ready(ready16), .div_zero(dz16)
   );

   function automatic int lzc(logic [15:0] v, int w);
      int n = 0;
      for (int i = w - 1; i >= 0; i--) begin
         if (v[i]) break;
         n++;
      end
      return n;
   endfunction

   task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge reset) begin
      for (int i = 0; i < 2; i++) begin
         if (reset || clear) begin
            m_act[i] <= 1'b0;
            m_raw[i] <= '0;
            m_lz[i]  <= 0;
            m_t[i]   <= 0;
         end else if (load) begin
            m_act[i] <= 1'b1;
            m_raw[i] <= (i == 0) ? {8'h00, din[7:0]} : din;
            m_lz[i]  <= lzc((i == 0) ? {8'h00, din[7:0]} : din, (i == 0) ? 8 : 16);
            m_t[i]   <= 0;
         end else if (m_act[i] && m_t[i] < 1000) begin
            m_t[i] <= m_t[i] + 1;
         end
      end
   end

   // every-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         for (int i = 0; i < 2; i++) begin
            int w, s;
            logic [15:0] mask, e_norm, e_raw, e_cnt;
            logic e_busy, e_ready, e_dz;
            logic [15:0] a_raw, a_norm, a_cnt;
            logic a_busy, a_ready, a_dz;
            w    = (i == 0) ? 8 : 16;
            mask = (i == 0) ? 16'h00FF : 16'hFFFF;
            if (!m_act[i]) begin
               e_raw = '0; e_norm = '0; e_cnt = '0;
               e_busy = 1'b0; e_ready = 1'b0; e_dz = 1'b0;
            end else if (m_raw[i] == 16'h0) begin
               e_raw = '0; e_norm = '0; e_cnt = '0;
               e_busy = 1'b0; e_ready = 1'b1; e_dz = 1'b1;
            end else begin
               s       = (m_t[i] < m_lz[i]) ? m_t[i] : m_lz[i];
               e_raw   = m_raw[i];
               e_norm  = (m_raw[i] << s) & mask;
               e_cnt   = 16'(s);
               e_busy  = (m_t[i] < m_lz[i]);
               e_ready = !e_busy;
               e_dz    = 1'b0;
            end
            a_raw   = (i == 0) ? {8'h00, raw8}  : raw16;
            a_norm  = (i == 0) ? {8'h00, norm8} : norm16;
            a_cnt   = (i == 0) ? {13'h0, cnt8}  : {12'h0, cnt16};
            a_busy  = (i == 0) ? busy8  : busy16;
            a_ready = (i == 0) ? ready8 : ready16;
            a_dz    = (i == 0) ? dz8    : dz16;
            chk($sformatf("w%0d_raw", w),   a_raw,  e_raw);
            chk($sformatf("w%0d_norm", w),  a_norm, e_norm);
            chk($sformatf("w%0d_cnt", w),   a_cnt,  e_cnt);
            chk($sformatf("w%0d_busy", w),  16'(a_busy),  16'(e_busy));
            chk($sformatf("w%0d_ready", w), 16'(a_ready), 16'(e_ready));
            chk($sformatf("w%0d_dz", w),    16'(a_dz),    16'(e_dz));
            if (a_ready && !a_dz) begin
               chk($sformatf("w%0d_norm_eq_raw_shl", w), a_norm, (a_raw << a_cnt) & mask);
               chk($sformatf("w%0d_msb", w), 16'(a_norm[w-1]), 16'h1);
            end
         end
      end
   end

   task automatic do_load(logic [15:0] d);
      load = 1'b1; din = d;
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      int n8, n16, busy_cnt;
      reset = 1'b1; load = 1'b0; clear = 1'b0; din = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_norm8", {8'h0, norm8}, 16'h0);
      chk("rst_ready16", {15'h0, ready16}, 16'h0);

      // 0x0001: 8-bit busy 7 cycles, 16-bit ready after 15 shifts
      do_load(16'h0001);
      n8 = 0; n16 = 0; busy_cnt = 0;
      while (!ready16 && n16 < 40) begin
         if (busy8) busy_cnt++;
         if (!ready8) n8++;
         n16++;
         @(negedge clk);
      end
      chk("w8_busy_cycles", 16'(busy_cnt), 16'd7);
      chk("w8_ready_cycle", 16'(n8 + 1), 16'd8);
      chk("w16_ready_cycle", 16'(n16 + 1), 16'd16);
      chk("w8_norm_01", {8'h0, norm8}, 16'h0080);
      chk("w8_cnt_01", {13'h0, cnt8}, 16'd7);
      chk("w8_raw_01", {8'h0, raw8}, 16'h0001);
      chk("w16_norm_0001", norm16, 16'h8000);
      chk("w16_cnt_0001", {12'h0, cnt16}, 16'd15);

      do_load(16'h00A5);
      chk("w8_A5_ready", {15'h0, ready8}, 16'h1);
      chk("w8_A5_norm", {8'h0, norm8}, 16'h00A5);
      chk("w8_A5_cnt", {13'h0, cnt8}, 16'h0);
      chk("w8_A5_busy", {15'h0, busy8}, 16'h0);

      do_load(16'h0000);
      chk("w8_zero_dz", {15'h0, dz8}, 16'h1);
      chk("w8_zero_ready", {15'h0, ready8}, 16'h1);
      chk("w16_zero_norm", norm16, 16'h0);
      do_load(16'h0030);
      chk("w8_30_dz_edge", {15'h0, dz8}, 16'h0);
      repeat (2) @(negedge clk);
      chk("w8_30_ready", {15'h0, ready8}, 16'h1);
      chk("w8_30_norm", {8'h0, norm8}, 16'h00C0);
      chk("w8_30_cnt", {13'h0, cnt8}, 16'd2);

      // reload 0x10 on the 3rd NORM cycle of 0x01
      do_load(16'h0001);
      repeat (2) @(negedge clk);
      do_load(16'h0010);
      repeat (3) @(negedge clk);
      chk("w8_reload_ready", {15'h0, ready8}, 16'h1);
      chk("w8_reload_norm", {8'h0, norm8}, 16'h0080);
      chk("w8_reload_cnt", {13'h0, cnt8}, 16'd3);

      clear = 1'b1;
      do_load(16'h0040);
      clear = 1'b0;
      chk("w8_clrld_raw", {8'h0, raw8}, 16'h0);
      chk("w8_clrld_busy", {15'h0, busy8}, 16'h0);
      chk("w16_clrld_ready", {15'h0, ready16}, 16'h0);

      // async reset mid-NORM
      do_load(16'h0001);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("w8_rst_mid_norm", {8'h0, norm8}, 16'h0);
      chk("w8_rst_mid_busy", {15'h0, busy8}, 16'h0);
      chk("w16_rst_mid_cnt", {12'h0, cnt16}, 16'h0);
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);

      // random sweep, including reloads mid-NORM and clears
      for (int it = 0; it < 400; it++) begin
         int r;
         logic [15:0] d;
         r = int'($urandom_range(0, 15));
         d = 16'($urandom >> $urandom_range(0, 16));
         if (r == 0) d = 16'h0;
         if (r == 1) begin
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
         end else begin
            do_load(d);
         end
         repeat ($urandom_range(0, 18)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
